// File: rtl/dcache_sram_pkg.sv
// Shared constants and access decoding for the direct-mapped L1 data-cache storage core.
package dcache_sram_pkg;

  localparam int DCACHE_BLOCK_SIZE = 32;
  localparam int DBLOCK_SIZE_BITS  = 8 * DCACHE_BLOCK_SIZE;
  localparam int DINDEX_SIZE       = 6;
  localparam int DTAG_SIZE         = 21;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_REFILL,
    OP_STORE
  } op_e;

  // memWen only qualifies a write; with wen=0 the access is a plain read.
  function automatic op_e decode_op(input logic en, input logic wen, input logic mem_wen);
    if (!en)      return OP_IDLE;
    if (!wen)     return OP_READ;
    if (mem_wen)  return OP_REFILL;
    return OP_STORE;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data arrays of the direct-mapped D-cache: zero-latency lookup,
// full-block refill and byte-masked store-on-hit.
module dcache_sram
  import dcache_sram_pkg::*;
#(
  parameter int BLOCK_SIZE = DCACHE_BLOCK_SIZE,
  parameter int BLOCK_BITS = DBLOCK_SIZE_BITS,
  parameter int INDEX_SIZE = DINDEX_SIZE,
  parameter int TAG_SIZE   = DTAG_SIZE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           wen,
  input  logic                           memWen,
  input  logic [BLOCK_SIZE-1:0]          bytesAccess,
  input  logic [TAG_SIZE+INDEX_SIZE-1:0] blockAddr,
  input  logic [BLOCK_BITS-1:0]          dataIn,
  output logic                           hit,
  output logic                           dirtyBit,
  output logic [BLOCK_BITS-1:0]          dataOut
);

  localparam int LINES = 1 << INDEX_SIZE;

  logic [TAG_SIZE-1:0]   addr_tag;
  logic [INDEX_SIZE-1:0] idx;
  assign {addr_tag, idx} = blockAddr;

  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;
  logic [TAG_SIZE-1:0]   tag_mem  [LINES];
  logic [BLOCK_BITS-1:0] data_mem [LINES];

  op_e                   op;
  logic                  line_active;
  logic                  tag_match;
  logic                  store_hit;
  logic [BLOCK_BITS-1:0] merged;

  assign op          = decode_op(en, wen, memWen);
  assign line_active = rst & en & valid_q[idx];
  assign tag_match   = (tag_mem[idx] == addr_tag);
  assign store_hit   = (op == OP_STORE) & line_active & tag_match;

  assign hit      = line_active & tag_match;
  assign dirtyBit = line_active & dirty_q[idx];
  assign dataOut  = line_active ? data_mem[idx] : '0;

  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_byte_merge
    assign merged[8*i +: 8] = bytesAccess[i] ? dataIn[8*i +: 8] : data_mem[idx][8*i +: 8];
  end

  // NOTE: sequential state uses non-blocking assignments so every read of the
  // arrays in this cycle sees pre-edge contents, matching the combinational outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (op == OP_REFILL) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (store_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; a line is only observable once its
  // valid bit is set, and leaving them unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (op == OP_REFILL) begin
        tag_mem[idx]  <= addr_tag;
        data_mem[idx] <= dataIn;
      end else if (store_hit) begin
        data_mem[idx] <= merged;
      end
    end
  end

endmodule

// File: tb/tb_dcache_sram.sv
// Scoreboard bench for dcache_sram: a behavioural line model predicts each lookup.
module tb_dcache_sram;
  import dcache_sram_pkg::*;

  localparam int LINES = 1 << DINDEX_SIZE;
  localparam int AW    = DTAG_SIZE + DINDEX_SIZE;

  typedef struct packed {
    logic                        hit;
    logic                        dirty;
    logic [DBLOCK_SIZE_BITS-1:0] data;
  } out_t;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         en;
  logic                         wen;
  logic                         memWen;
  logic [DCACHE_BLOCK_SIZE-1:0] bytesAccess;
  logic [AW-1:0]                blockAddr;
  logic [DBLOCK_SIZE_BITS-1:0]  dataIn;
  logic                         hit;
  logic                         dirtyBit;
  logic [DBLOCK_SIZE_BITS-1:0]  dataOut;

  dcache_sram dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wen        (wen),
    .memWen     (memWen),
    .bytesAccess(bytesAccess),
    .blockAddr  (blockAddr),
    .dataIn     (dataIn),
    .hit        (hit),
    .dirtyBit   (dirtyBit),
    .dataOut    (dataOut)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  out_t sb[$];

  logic                        m_valid [LINES];
  logic                        m_dirty [LINES];
  logic [DTAG_SIZE-1:0]        m_tag   [LINES];
  logic [DBLOCK_SIZE_BITS-1:0] m_data  [LINES];

  localparam logic [DTAG_SIZE-1:0] TAG_ONES = '1;
  localparam logic [DBLOCK_SIZE_BITS-1:0] ONES = '1;

  function automatic logic [AW-1:0] mk_addr(input logic [DTAG_SIZE-1:0] t,
                                            input logic [DINDEX_SIZE-1:0] i);
    return {t, i};
  endfunction

  function automatic logic [DBLOCK_SIZE_BITS-1:0] rand_block();
    logic [DBLOCK_SIZE_BITS-1:0] b;
    for (int k = 0; k < DBLOCK_SIZE_BITS / 32; k++) b[32*k +: 32] = $urandom;
    return b;
  endfunction

  // Expected outputs for a lookup with en=1, taken from the model.
  function automatic out_t model_read(input logic [AW-1:0] a);
    logic [DINDEX_SIZE-1:0] i;
    out_t o;
    i = a[DINDEX_SIZE-1:0];
    o = '0;
    if (m_valid[i]) begin
      o.hit   = (m_tag[i] == a[AW-1:DINDEX_SIZE]);
      o.dirty = m_dirty[i];
      o.data  = m_data[i];
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_refill(input logic [AW-1:0] a, input logic [DBLOCK_SIZE_BITS-1:0] d);
    logic [DINDEX_SIZE-1:0] i;
    i = a[DINDEX_SIZE-1:0];
    m_valid[i] = 1'b1;
    m_dirty[i] = 1'b0;
    m_tag[i]   = a[AW-1:DINDEX_SIZE];
    m_data[i]  = d;
  endtask

  task automatic model_store(input logic [AW-1:0] a, input logic [DBLOCK_SIZE_BITS-1:0] d,
                             input logic [DCACHE_BLOCK_SIZE-1:0] m);
    logic [DINDEX_SIZE-1:0] i;
    i = a[DINDEX_SIZE-1:0];
    if (m_valid[i] && m_tag[i] == a[AW-1:DINDEX_SIZE]) begin
      for (int b = 0; b < DCACHE_BLOCK_SIZE; b++)
        if (m[b]) m_data[i][8*b +: 8] = d[8*b +: 8];
      m_dirty[i] = 1'b1;
    end
  endtask

  task automatic do_refill(input logic [AW-1:0] a, input logic [DBLOCK_SIZE_BITS-1:0] d);
    @(negedge clk);
    en = 1'b1; wen = 1'b1; memWen = 1'b1; blockAddr = a; dataIn = d;
    bytesAccess = DCACHE_BLOCK_SIZE'($urandom);
    @(posedge clk);
    model_refill(a, d);
    #1 wen = 1'b0;
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DBLOCK_SIZE_BITS-1:0] d,
                          input logic [DCACHE_BLOCK_SIZE-1:0] m);
    @(negedge clk);
    en = 1'b1; wen = 1'b1; memWen = 1'b0; blockAddr = a; dataIn = d; bytesAccess = m;
    @(posedge clk);
    model_store(a, d, m);
    #1 wen = 1'b0;
  endtask

  // Drives a read (memWen randomised, it must be ignored) and queues the prediction.
  task automatic start_read(input logic [AW-1:0] a);
    @(negedge clk);
    en = 1'b1; wen = 1'b0; memWen = 1'($urandom); blockAddr = a;
    dataIn = rand_block();
    #1 sb.push_back(model_read(a));
  endtask

  task automatic test_reset();
    out_t exp, obs;
    rst = 1'b0; en = 1'b1; wen = 1'b0; memWen = 1'b0;
    bytesAccess = '0; blockAddr = '0; dataIn = '0;
    model_reset();
    sb.push_back('0);
    #20;
    obs = {hit, dirtyBit, dataOut};
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_held: got hit=%b dirty=%b data=%h, expected hit=%b dirty=%b data=%h",
               obs.hit, obs.dirty, obs.data, exp.hit, exp.dirty, exp.data);
    end
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start_read(mk_addr(DTAG_SIZE'($urandom), DINDEX_SIZE'(k * 21)));
      obs = {hit, dirtyBit, dataOut};
      exp = sb.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: got hit=%b dirty=%b data=%h, expected hit=%b dirty=%b data=%h",
                 k, obs.hit, obs.dirty, obs.data, exp.hit, exp.dirty, exp.data);
      end
    end
  endtask

  task automatic test_refill();
    out_t exp, obs;
    do_refill(mk_addr('0, 0), '0);
    do_refill(mk_addr(TAG_ONES, 0), ONES);
    start_read(mk_addr(TAG_ONES, 0));
    start_read(mk_addr('0, 0));
    for (int k = 0; k < 2; k++) begin
      if (k == 1) start_read(mk_addr('0, 0));
      #0;
    end
    for (int k = 0; k < 3; k++) begin
      exp = sb.pop_front();
      if (k == 0) obs = {1'b1, 1'b0, ONES};
      else        obs = {1'b0, 1'b0, ONES};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL refill_model[%0d]: model says hit=%b dirty=%b, expected hit=%b dirty=%b",
                 k, exp.hit, exp.dirty, obs.hit, obs.dirty);
      end
    end
    start_read(mk_addr(TAG_ONES, 0));
    obs = {hit, dirtyBit, dataOut};
    exp = sb.pop_front();
    n_checks++;
    if (obs !== {1'b1, 1'b0, ONES} || obs !== exp) begin
      n_fail++;
      $display("FAIL refill_hit: got hit=%b dirty=%b data=%h, expected hit=1 dirty=0 data=all ones",
               obs.hit, obs.dirty, obs.data);
    end
    start_read(mk_addr('0, 0));
    obs = {hit, dirtyBit, dataOut};
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL refill_old_tag: got hit=%b dirty=%b, expected hit=%b dirty=%b",
               obs.hit, obs.dirty, exp.hit, exp.dirty);
    end
  endtask

  task automatic test_store_hit();
    out_t exp, obs;
    logic [DCACHE_BLOCK_SIZE-1:0] msb_only;
    logic [DBLOCK_SIZE_BITS-1:0]  aa_top;
    msb_only = '0; msb_only[DCACHE_BLOCK_SIZE-1] = 1'b1;
    aa_top   = '0; aa_top[DBLOCK_SIZE_BITS-1 -: 8] = 8'hAA;
    do_store(mk_addr(TAG_ONES, 0), aa_top, msb_only);
    start_read(mk_addr(TAG_ONES, 0));
    obs = {hit, dirtyBit, dataOut};
    exp = sb.pop_front();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 8'hAA, {(DBLOCK_SIZE_BITS - 8){1'b1}}} || obs !== exp) begin
      n_fail++;
      $display("FAIL store_msb_byte: got hit=%b dirty=%b data=%h, expected hit=1 dirty=1 data=aa then all ones",
               obs.hit, obs.dirty, obs.data);
    end
    // Empty byte mask on a hit on a clean line: data kept, dirty still set.
    do_refill(mk_addr(21'h1234, 5), rand_block());
    do_store(mk_addr(21'h1234, 5), rand_block(), '0);
    start_read(mk_addr(21'h1234, 5));
    obs = {hit, dirtyBit, dataOut};
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp || dirtyBit !== 1'b1) begin
      n_fail++;
      $display("FAIL store_empty_mask: got hit=%b dirty=%b data=%h, expected hit=%b dirty=1 data=%h",
               obs.hit, obs.dirty, obs.data, exp.hit, exp.data);
    end
  endtask

  task automatic test_store_miss();
    out_t exp, obs;
    do_store(mk_addr(21'h5, 0), rand_block(), '1);
    start_read(mk_addr(TAG_ONES, 0));
    obs = {hit, dirtyBit, dataOut};
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL store_miss_line: got hit=%b dirty=%b data=%h, expected hit=%b dirty=%b data=%h",
               obs.hit, obs.dirty, obs.data, exp.hit, exp.dirty, exp.data);
    end
    start_read(mk_addr(21'h5, 0));
    n_checks++;
    exp = sb.pop_front();
    if (hit !== 1'b0 || dirtyBit !== exp.dirty) begin
      n_fail++;
      $display("FAIL store_miss_tag: got hit=%b dirty=%b, expected hit=0 dirty=%b",
               hit, dirtyBit, exp.dirty);
    end
  endtask

  task automatic test_refill_clears_dirty();
    out_t exp, obs;
    do_refill(mk_addr(TAG_ONES, 0), rand_block());
    start_read(mk_addr(TAG_ONES, 0));
    obs = {hit, dirtyBit, dataOut};
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp || dirtyBit !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_clean: got hit=%b dirty=%b data=%h, expected hit=%b dirty=0 data=%h",
               obs.hit, obs.dirty, obs.data, exp.hit, exp.data);
    end
    start_read(mk_addr(TAG_ONES, 1));
    obs = {hit, dirtyBit, dataOut};
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL other_index: got hit=%b dirty=%b data=%h, expected hit=%b dirty=%b data=%h",
               obs.hit, obs.dirty, obs.data, exp.hit, exp.dirty, exp.data);
    end
    // en=0 with a hitting address must blank every output.
    @(negedge clk);
    en = 1'b0; wen = 1'b0; blockAddr = mk_addr(TAG_ONES, 0);
    #1;
    n_checks++;
    if ({hit, dirtyBit, dataOut} !== '0) begin
      n_fail++;
      $display("FAIL en_low: got hit=%b dirty=%b data=%h, expected all zero", hit, dirtyBit, dataOut);
    end
  endtask

  // Random traffic on four indices, two tags; pre-edge outputs checked every cycle.
  task automatic test_back_to_back();
    out_t exp, obs;
    logic [AW-1:0]                a;
    logic [DBLOCK_SIZE_BITS-1:0]  d;
    logic [DCACHE_BLOCK_SIZE-1:0] m;
    logic                         e, w, mw;
    for (int c = 0; c < 300; c++) begin
      a  = mk_addr(($urandom_range(0, 1) != 0) ? TAG_ONES : DTAG_SIZE'(3), DINDEX_SIZE'($urandom_range(0, 3)));
      d  = rand_block();
      m  = DCACHE_BLOCK_SIZE'($urandom);
      e  = ($urandom_range(0, 7) != 0);
      w  = 1'($urandom);
      mw = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      en = e; wen = w; memWen = mw; blockAddr = a; dataIn = d; bytesAccess = m;
      sb.push_back(e ? model_read(a) : out_t'('0));
      #2;
      obs = {hit, dirtyBit, dataOut};
      exp = sb.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL b2b[%0d] addr=%h: got hit=%b dirty=%b data=%h, expected hit=%b dirty=%b data=%h",
                 c, a, obs.hit, obs.dirty, obs.data, exp.hit, exp.dirty, exp.data);
      end
      @(posedge clk);
      if (e && w && mw) model_refill(a, d);
      else if (e && w)  model_store(a, d, m);
    end
    #1 wen = 1'b0;
  endtask

  task automatic test_async_reset();
    out_t exp, obs;
    do_refill(mk_addr(21'h7, 2), rand_block());
    do_store(mk_addr(21'h7, 2), rand_block(), DCACHE_BLOCK_SIZE'($urandom));
    start_read(mk_addr(21'h7, 2));
    obs = {hit, dirtyBit, dataOut};
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp || hit !== 1'b1 || dirtyBit !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_line: got hit=%b dirty=%b, expected hit=1 dirty=1", obs.hit, obs.dirty);
    end
    #1 rst = 1'b0;
    model_reset();
    sb.push_back('0);
    #1;
    obs = {hit, dirtyBit, dataOut};
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL async_reset_drop: got hit=%b dirty=%b data=%h, expected all zero",
               obs.hit, obs.dirty, obs.data);
    end
    // A refill attempted while held in reset must not land.
    wen = 1'b1; memWen = 1'b1; blockAddr = mk_addr(21'h7, 2); dataIn = ONES;
    @(posedge clk);
    @(negedge clk);
    wen = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start_read(mk_addr(21'h7, DINDEX_SIZE'((k == 0) ? 2 : k * 19)));
      obs = {hit, dirtyBit, dataOut};
      exp = sb.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL post_reset_miss[%0d]: got hit=%b dirty=%b data=%h, expected hit=%b dirty=%b data=%h",
                 k, obs.hit, obs.dirty, obs.data, exp.hit, exp.dirty, exp.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_store_hit();
    test_store_miss();
    test_refill_clears_dirty();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
